// File: rtl/ifq_multi_issue.sv
// Instruction fetch queue: fetches LINE_WORDS-wide lines, buffers instructions with their PCs,
// and presents up to DISP_W oldest entries per cycle to dispatch. Redirects flush and refetch.
module ifq_multi_issue #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISP_W     = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          d_valid,
    input  logic [32*LINE_WORDS-1:0]      mem_data,
    output logic                          abort,
    output logic                          m_rd_en,
    output logic [31:0]                   mem_addr,
    input  logic                          jump_branch_valid,
    input  logic [31:0]                   jump_branch_add,
    input  logic [$clog2(DISP_W+1)-1:0]   d_rd_cnt,
    output logic [$clog2(DISP_W+1)-1:0]   avail_cnt,
    output logic                          empty,
    output logic [32*DISP_W-1:0]          i_code,
    output logic [32*DISP_W-1:0]          pc_out
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RW   = $clog2(DISP_W + 1);
    localparam int OFFW = $clog2(LINE_WORDS);
    localparam int LB   = OFFW + 2;

    typedef enum logic {IDLE, REQ} state_e;

    state_e          state_q, state_d;
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;

    logic [OFFW-1:0] off;
    logic [31:0]     line_addr;
    logic            wr_en;
    logic            has_room;
    logic [CW-1:0]   written;
    logic [CW-1:0]   consume;
    logic [RW-1:0]   consume_r;
    logic [AW-1:0]   wr_idx [LINE_WORDS];
    logic            unused_pc_lsb;

    assign off           = fetch_pc_q[LB-1:2];
    assign line_addr     = {fetch_pc_q[31:LB], {LB{1'b0}}};
    assign mem_addr      = line_addr;
    assign unused_pc_lsb = ^fetch_pc_q[1:0];

    assign empty     = (count_q == '0);
    assign avail_cnt = (count_q < CW'(DISP_W)) ? RW'(count_q) : RW'(DISP_W);
    // Over-read saturates to what is actually presented.
    assign consume_r = (d_rd_cnt < avail_cnt) ? d_rd_cnt : avail_cnt;
    assign consume   = CW'(consume_r);

    assign wr_en   = (state_q == REQ) && d_valid && !jump_branch_valid;
    assign written = CW'(LINE_WORDS) - CW'(off);

    // Word i of the line lands at wr_ptr + (i - off); words below off are dropped.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            wr_idx[i] = wr_ptr_q + AW'(i) - AW'(off);
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        m_rd_en    = 1'b0;
        abort      = 1'b0;
        has_room   = 1'b0;
        if (jump_branch_valid) begin
            // Queue is empty after the flush, so the new target is requested right away.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = jump_branch_add;
            state_d    = REQ;
            abort      = (state_q == REQ) && !d_valid;
        end else begin
            m_rd_en  = (state_q == REQ);
            rd_ptr_d = rd_ptr_q + AW'(consume);
            count_d  = count_q + (wr_en ? written : '0) - consume;
            if (wr_en) begin
                wr_ptr_d   = wr_ptr_q + AW'(written);
                fetch_pc_d = line_addr + 32'(4 * LINE_WORDS);
            end
            has_room = (count_d <= CW'(DEPTH - LINE_WORDS));
            case (state_q)
                IDLE:    if (has_room) state_d = REQ;
                REQ:     if (d_valid) state_d = has_room ? REQ : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            if (wr_en) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (i >= int'(off)) begin
                        instr_q[wr_idx[i]] <= mem_data[32*i +: 32];
                        pc_q[wr_idx[i]]    <= line_addr + 32'(4 * i);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_slot
        logic [AW-1:0] idx;
        assign idx                 = rd_ptr_q + AW'(k);
        assign i_code[32*k +: 32]  = instr_q[idx];
        assign pc_out[32*k +: 32]  = pc_q[idx];
    end

endmodule
